// File: rtl/imem_boot_loader.sv
// Boot loader: takes a byte stream (16-bit word count, then big-endian words), writes
// instruction memory from address 0, zero-fills the rest, then releases the CPU reset.
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_byte,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);
    typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, FILL, DONE, ERROR} state_t;

    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [16:0]         DEPTH_W   = 17'(DEPTH);

    state_t                state_q, state_d;
    logic [15:0]           n_q, n_d;
    logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           shift_q, shift_d;
    logic                  in_ready_q, in_ready_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  accept;

    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        word_cnt_d  = word_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
        error_d     = error_q;

        case (state_q)
            HDR_HI: begin
                if (accept) begin
                    n_d     = {in_byte, 8'h00};
                    state_d = HDR_LO;
                end
            end
            HDR_LO: begin
                if (accept) begin
                    n_d = {n_q[15:8], in_byte};
                    if ({1'b0, n_d} > DEPTH_W)
                        state_d = ERROR;
                    else if (n_d == 16'd0)
                        state_d = FILL;
                    else
                        state_d = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    shift_d    = {shift_q[15:0], in_byte};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        we_d       = 1'b1;
                        addr_d     = word_cnt_q[ADDR_WIDTH-1:0];
                        wdata_d    = {shift_q, in_byte};
                        word_cnt_d = word_cnt_q + 1'b1;
                        if (17'(word_cnt_d) == {1'b0, n_q})
                            state_d = (17'(word_cnt_d) == DEPTH_W) ? DONE : FILL;
                    end
                end
            end
            FILL: begin
                // word_cnt_q continues from N, so fill addresses follow the data directly
                we_d       = 1'b1;
                addr_d     = word_cnt_q[ADDR_WIDTH-1:0];
                wdata_d    = 32'd0;
                word_cnt_d = word_cnt_q + 1'b1;
                if (word_cnt_q == LAST_ADDR)
                    state_d = DONE;
            end
            DONE: begin
                done_d      = 1'b1;
                cpu_reset_d = 1'b0;
            end
            ERROR: begin
                error_d     = 1'b1;
                cpu_reset_d = 1'b1;
            end
            default: state_d = HDR_HI;
        endcase

        in_ready_d = (state_d == HDR_HI) || (state_d == HDR_LO) || (state_d == DATA);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HDR_HI;
            n_q         <= '0;
            word_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            in_ready_q  <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            word_cnt_q  <= word_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            in_ready_q  <= in_ready_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign error      = error_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: streams programs with random gaps and compares the
// observed write trace against the expected memory image built from the program.
module tb_imem_boot_loader;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_byte = 8'h00;
    logic          in_ready, imem_we, cpu_reset, done, error;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    imem_boot_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_byte(in_byte), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int done_cyc = -1;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;
    wr_t wr_q[$];

    // Program under test: header count and the words that follow it
    logic [15:0] n_hdr;
    logic [31:0] words[$];

    always @(negedge clk) begin
        cyc++;
        if (imem_we) wr_q.push_back('{int'(imem_addr), imem_wdata, cyc});
        if (done && done_cyc < 0) done_cyc = cyc;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_we", 32'(imem_we), 0);
        check("rst_addr", 32'(imem_addr), 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_cpu_reset", 32'(cpu_reset), 1);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        wr_q.delete();
        done_cyc = -1;
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(in_ready), 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            compared++;
            mismatched++;
            $error("FAIL accept_timeout: observed in_ready=0 expected 1 for byte %h", b);
        end
        @(posedge clk);
    endtask

    task automatic send_program(input int maxgap);
        logic [31:0] w;
        send_byte(n_hdr[15:8], $urandom_range(0, maxgap));
        send_byte(n_hdr[7:0], $urandom_range(0, maxgap));
        for (int k = 0; k < words.size(); k++) begin
            w = words[k];
            send_byte(w[31:24], $urandom_range(0, maxgap));
            send_byte(w[23:16], $urandom_range(0, maxgap));
            send_byte(w[15:8], $urandom_range(0, maxgap));
            send_byte(w[7:0], $urandom_range(0, maxgap));
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Expected image: program words, then zeros; one write per address in ascending order
    task automatic check_load(input string name);
        int t;
        int n;
        int nwr;
        logic [31:0] exp;
        n = int'(n_hdr);
        t = 0;
        while (!done && t < DEPTH + 100) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check({name, "_done"}, 32'(done), 1);
        check({name, "_cpu_reset"}, 32'(cpu_reset), 0);
        check({name, "_error"}, 32'(error), 0);
        check({name, "_write_count"}, 32'(wr_q.size()), DEPTH);
        for (int i = 0; i < wr_q.size(); i++) begin
            exp = (i < n) ? words[i] : 32'd0;
            check($sformatf("%s_addr%0d", name, i), 32'(wr_q[i].addr), 32'(i));
            check($sformatf("%s_data%0d", name, i), wr_q[i].data, exp);
            if (i > 0 && i >= n)
                check($sformatf("%s_fill_gap%0d", name, i), 32'(wr_q[i].cyc),
                      32'(wr_q[i-1].cyc + 1));
        end
        if (wr_q.size() > 0)
            check({name, "_done_timing"}, 32'(done_cyc), 32'(wr_q[wr_q.size()-1].cyc + 1));
        // Extra stream bytes must be refused once loaded
        nwr = wr_q.size();
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = 8'hA5;
        repeat (6) begin
            @(negedge clk);
            check({name, "_no_extra_ready"}, 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        check({name, "_no_extra_writes"}, 32'(wr_q.size()), 32'(nwr));
        check({name, "_done_held"}, 32'(done), 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);

        // Two-word program
        do_reset();
        n_hdr = 16'd2;
        words = '{32'h20080005, 32'h21090007};
        send_program(0);
        check_load("n2");

        // Empty program: fill only
        do_reset();
        n_hdr = 16'd0;
        words.delete();
        send_program(0);
        check_load("n0");

        // Full memory, no fill
        do_reset();
        n_hdr = 16'(DEPTH);
        words.delete();
        for (int k = 0; k < DEPTH; k++) words.push_back(32'(k));
        send_program(0);
        check_load("nfull");

        // Oversized header
        do_reset();
        n_hdr = 16'(DEPTH + 1);
        words.delete();
        send_program(0);
        repeat (20) @(negedge clk);
        check("err_error", 32'(error), 1);
        check("err_in_ready", 32'(in_ready), 0);
        check("err_cpu_reset", 32'(cpu_reset), 1);
        check("err_done", 32'(done), 0);
        check("err_writes", 32'(wr_q.size()), 0);

        // Single word with valid gaps
        do_reset();
        n_hdr = 16'd1;
        words = '{32'hDEADBEEF};
        send_program(5);
        check_load("gaps");

        // Reset in the middle of a word, then a fresh program
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        do_reset();
        n_hdr = 16'd1;
        words = '{32'h01234567};
        send_program(0);
        check_load("midrst");

        // Random programs with random gaps
        for (int r = 0; r < 3; r++) begin
            do_reset();
            n_hdr = 16'($urandom_range(1, 40));
            words.delete();
            for (int k = 0; k < int'(n_hdr); k++) words.push_back($urandom);
            send_program(3);
            check_load($sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
